dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the target end of the processor's load/store interface.
- Accepts one request at a time from the MEM stage over a valid/ready handshake.
- Performs byte, half or word access selected by funct3.
- Returns data or a write ack after a fixed latency; the response is held until the pipeline accepts it.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words of storage; power of two, minimum 4.
- LATENCY, 2, cycles from request acceptance to first rsp_valid; minimum 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  access type (RV32I load/store funct3).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; low byte/half used for SB/SH.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  pipeline accepts response.
- rsp_rdata  output  32  load result, extended per funct3; 0 for stores and errors.
- rsp_err  output  1  misaligned or illegal funct3.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
  - All DEPTH_WORDS words cleared to 0.
  - Reset mid-operation aborts the request; a pending store is discarded (memory is cleared anyway).
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready, capture we/funct3/addr/wdata, counter=LATENCY-1, go to WAIT.
  - WAIT: req_ready=0. Counter decrements each cycle. When counter==0 at the clock edge, perform the access, register rsp_rdata/rsp_err, and go to RESP.
  - RESP: rsp_valid=1, req_ready=0, response outputs held stable. On rsp_ready=1, go to IDLE with rsp_valid=0 the next cycle.
- Latency: request accepted at edge N → rsp_valid=1 from edge N+LATENCY. With rsp_ready tied high, the next request is accepted at edge N+LATENCY+2.
- Illegal requests while not ready: req_valid while req_ready=0 is ignored; the requester must hold it.
- Word index: req_addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Loads:
  - 000 LB: sign-extend selected byte.
  - 100 LBU: zero-extend selected byte.
  - 001 LH: sign-extend half at addr[1].
  - 101 LHU: zero-extend half at addr[1].
  - 010 LW: full word.
  - Byte lane = addr[1:0], little-endian.
- Stores:
  - 000 SB writes only lane addr[1:0] with wdata[7:0].
  - 001 SH writes the half at addr[1] with wdata[15:0].
  - 010 SW writes all 4 bytes.
  - Other bytes are untouched. Store response: rsp_rdata=0, rsp_err=0.
- Errors (rsp_err=1, rsp_rdata=0, memory unmodified, latency unchanged):
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - funct3 011/110/111 for loads.
  - funct3 other than 000/001/010 for stores.
- Read-after-write: a load accepted after a store's response completes returns the stored data.

Test Plan:
- Reset, then LW addr 0x10 → rsp_valid exactly 2 cycles after accept, rsp_rdata=0x00000000, rsp_err=0; req_ready=0 during WAIT/RESP.
- SW 0x80F1_7F02 @0x08, then:
  - LB @0x08 → 0x00000002.
  - LB @0x0B → 0xFFFFFF80.
  - LBU @0x0B → 0x00000080.
  - LH @0x0A → 0xFFFF80F1.
  - LHU @0x0A → 0x000080F1.
- SW 0xAABBCCDD @0x20, SB wdata 0x11 @0x21, SH wdata 0x2233 @0x22, then LW @0x20 → 0x223311DD.
- Misaligned and illegal requests:
  - LW @0x06 → rsp_err=1, rdata=0.
  - SH @0x05 → rsp_err=1, and a subsequent LW @0x04 shows unchanged data.
  - Load funct3=011 → rsp_err=1.
- Backpressure and wrap:
  - Hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stable, req_valid ignored; on rsp_ready=1, IDLE next cycle.
  - SW @0x100 with DEPTH_WORDS=64 aliases to @0x000; LW @0x000 returns it.
- Reset mid-operation: assert rst in WAIT of a SW 0x12345678 @0x0C → next cycle IDLE, rsp_valid=0; LW @0x0C → 0x00000000.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle byte/half/word data-memory target with valid/ready request and held response
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [31:0] mem [DEPTH_WORDS];
  logic [CW-1:0] cnt;
  logic we;
  logic [2:0] f3;
  logic [AW+1:0] a;
  logic [31:0] wdata_q, word, ld, wr, rep;
  logic [7:0] bsel;
  logic [15:0] hsel;
  logic [3:0] be;
  logic err;
  logic unused_addr;
  assign unused_addr = ^req_addr[31:AW+2];
  always_comb begin
    word = mem[a[AW+1:2]];
    bsel = word[{a[1:0], 3'b000} +: 8];
    hsel = a[1] ? word[31:16] : word[15:0];
    ld = f3[1:0] == 2'b00 ? {{24{bsel[7] & ~f3[2]}}, bsel} :
         f3[1:0] == 2'b01 ? {{16{hsel[15] & ~f3[2]}}, hsel} : word;
    be = f3[1:0] == 2'b00 ? 4'b0001 << a[1:0] :
         f3[1:0] == 2'b01 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    rep = f3[1:0] == 2'b00 ? {4{wdata_q[7:0]}} :
          f3[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
    err = (we ? f3 > 3'd2 : (&f3[1:0] || &f3[2:1])) ||
          (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && |a[1:0]);
    wr = word;
    for (int i = 0; i < 4; i++) wr[i*8 +: 8] = be[i] ? rep[i*8 +: 8] : word[i*8 +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      cnt <= '0;
      we <= 1'b0;
      f3 <= '0;
      a <= '0;
      wdata_q <= '0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we <= req_we;
          f3 <= req_funct3;
          a <= req_addr[AW+1:0];
          wdata_q <= req_wdata;
          cnt <= CW'(LATENCY - 1);
          req_ready <= 1'b0;
          state <= WAIT;
        end
        WAIT: if (cnt == '0) begin
          if (we && !err) mem[a[AW+1:2]] <= wr;
          rsp_rdata <= (we || err) ? '0 : ld;
          rsp_err <= err;
          rsp_valid <= 1'b1;
          state <= RESP;
        end else cnt <= cnt - 1'b1;
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
